// File: rtl/sgf_mult_norm_round.sv
// Two-stage normalize/round pipeline for the raw significand product of the FPU multiplier.
// Stage 1 normalizes and extracts guard/sticky; stage 2 rounds and reports exponent/status flags.
module sgf_mult_norm_round #(
  parameter int SW = 54
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2*SW-1:0] product_i,
  input  logic            sign_i,
  input  logic [1:0]      rm_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [SW-2:0]   mant_o,
  output logic            exp_adj_o,
  output logic            inexact_o,
  output logic            unnorm_o
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Handshake / advance control
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_load;
  logic s2_load;

  assign s2_load    = ~s2_valid_reg | out_ready_i;
  assign s1_load    = ~s1_valid_reg | s2_load;
  assign in_ready_o = s1_load;

  // Stage 1: normalization of the incoming product
  logic          n_next;
  logic [SW-1:0] kept_next;
  logic          g_next;
  logic          s_next;
  logic          unnorm_next;

  always_comb begin
    n_next      = product_i[2*SW-1];
    unnorm_next = (product_i[2*SW-1:2*SW-2] == 2'b00);
    if (n_next) begin
      kept_next = product_i[2*SW-1:SW];
      g_next    = product_i[SW-1];
      s_next    = |product_i[SW-2:0];
    end else begin
      kept_next = product_i[2*SW-2:SW-1];
      g_next    = product_i[SW-2];
      s_next    = |product_i[SW-3:0];
    end
  end

  logic          s1_n_reg;
  logic [SW-1:0] s1_kept_reg;
  logic          s1_g_reg;
  logic          s1_s_reg;
  logic          s1_sign_reg;
  logic [1:0]    s1_rm_reg;
  logic          s1_unnorm_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg  <= 1'b0;
      s1_n_reg      <= 1'b0;
      s1_kept_reg   <= '0;
      s1_g_reg      <= 1'b0;
      s1_s_reg      <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_rm_reg     <= RM_RNE;
      s1_unnorm_reg <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= in_valid_i;
      end
      if (s1_load && in_valid_i) begin
        s1_n_reg      <= n_next;
        s1_kept_reg   <= kept_next;
        s1_g_reg      <= g_next;
        s1_s_reg      <= s_next;
        s1_sign_reg   <= sign_i;
        s1_rm_reg     <= rm_i;
        s1_unnorm_reg <= unnorm_next;
      end
    end
  end

  // Stage 2: rounding increment and carry-out
  logic          inc;
  logic          carry;
  logic [SW-2:0] mant_next;
  logic          exp_adj_next;
  logic          inexact_next;

  always_comb begin
    inc = 1'b0;
    unique case (s1_rm_reg)
      RM_RNE:  inc = s1_g_reg & (s1_s_reg | s1_kept_reg[0]);
      RM_RZ:   inc = 1'b0;
      RM_RUP:  inc = ~s1_sign_reg & (s1_g_reg | s1_s_reg);
      RM_RDN:  inc = s1_sign_reg & (s1_g_reg | s1_s_reg);
      default: inc = 1'b0;
    endcase
  end

  // Carry out of kept+inc only happens for an all-ones kept field, in which case the
  // truncated fraction sum wraps to zero exactly as a forced-zero mantissa would.
  always_comb begin
    carry        = inc & (&s1_kept_reg);
    mant_next    = s1_kept_reg[SW-2:0] + {{(SW-2){1'b0}}, inc};
    exp_adj_next = s1_n_reg | carry;
    inexact_next = s1_g_reg | s1_s_reg;
  end

  logic [SW-2:0] s2_mant_reg;
  logic          s2_exp_adj_reg;
  logic          s2_inexact_reg;
  logic          s2_unnorm_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg   <= 1'b0;
      s2_mant_reg    <= '0;
      s2_exp_adj_reg <= 1'b0;
      s2_inexact_reg <= 1'b0;
      s2_unnorm_reg  <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (s2_load && s1_valid_reg) begin
        s2_mant_reg    <= mant_next;
        s2_exp_adj_reg <= exp_adj_next;
        s2_inexact_reg <= inexact_next;
        s2_unnorm_reg  <= s1_unnorm_reg;
      end
    end
  end

  assign out_valid_o = s2_valid_reg;
  assign mant_o      = s2_mant_reg;
  assign exp_adj_o   = s2_exp_adj_reg;
  assign inexact_o   = s2_inexact_reg;
  assign unnorm_o    = s2_unnorm_reg;

endmodule
